// File: rtl/data_sram_like_bridge.sv
// Bridges a single-cycle CPU data SRAM port onto a split address/data
// handshaked bus, stalling the pipeline while an access is outstanding.
module data_sram_like_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,
    input  logic              cpu_longest_stall,
    output logic              data_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic              req_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              wr_d;
    logic [1:0]        size_d;
    logic [ADDR_W-1:0] addr_d;

    function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
        logic [1:0] size;
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
            4'b0011, 4'b1100:                   size = 2'd1;
            default:                            size = 2'd2;
        endcase
        return size;
    endfunction

    // Reads always fetch the whole aligned word; the CPU extracts bytes/halves.
    always_comb begin
        wr_d   = |data_sram_wen;
        size_d = wr_d ? wen_to_size(data_sram_wen) : 2'd2;
        addr_d = wr_d ? data_sram_addr : {data_sram_addr[ADDR_W-1:2], 2'b00};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_sram_en) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        wr_q    <= wr_d;
                        size_q  <= size_d;
                        addr_q  <= addr_d;
                        wdata_q <= data_sram_wdata;
                    end
                end
                REQ: begin
                    // data_ok is only meaningful once the address has been taken.
                    if (data_addr_ok) begin
                        req_q <= 1'b0;
                        if (data_data_ok) begin
                            state_q <= DONE;
                            if (!wr_q) begin
                                rdata_q <= data_rdata;
                            end
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (data_data_ok) begin
                        state_q <= DONE;
                        if (!wr_q) begin
                            rdata_q <= data_rdata;
                        end
                    end
                end
                DONE: begin
                    if (!cpu_longest_stall) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        data_stall = (state_q == REQ) || (state_q == WAIT) ||
                     ((state_q == IDLE) && data_sram_en);
    end

    assign data_req        = req_q;
    assign data_wr         = wr_q;
    assign data_size       = size_q;
    assign data_addr       = addr_q;
    assign data_wdata      = wdata_q;
    assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Directed bench for data_sram_like_bridge: bus responses are scripted per
// transaction and expected results flow through a scoreboard queue.
module tb_data_sram_like_bridge;

    logic        clk;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        cpu_longest_stall;
    logic        data_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          vectors;
    int          miscompares;
    logic [31:0] exp_rdata;

    data_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .data_sram_en      (data_sram_en),
        .data_sram_wen     (data_sram_wen),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_rdata   (data_sram_rdata),
        .cpu_longest_stall (cpu_longest_stall),
        .data_stall        (data_stall),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_rdata        (data_rdata),
        .data_addr_ok      (data_addr_ok),
        .data_data_ok      (data_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_size(input logic [3:0] w);
        case (w)
            4'b0000:                            return 2'd2;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 2'd0;
            4'b0011, 4'b1100:                   return 2'd1;
            default:                            return 2'd2;
        endcase
    endfunction

    function automatic exp_t make_exp(input logic [31:0] a, input logic [3:0] w,
                                      input logic [31:0] wd, input logic [31:0] rd);
        exp_t e;
        e.wr    = (w != 4'b0000);
        e.size  = exp_size(w);
        e.addr  = e.wr ? a : {a[31:2], 2'b00};
        e.wdata = wd;
        e.rdata = e.wr ? exp_rdata : rd;
        return e;
    endfunction

    task automatic chk_req_fields(input string tag);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_req"}, {31'd0, data_req}, 32'd1);
            chk({tag, "_addr"}, data_addr, sb[0].addr);
            chk({tag, "_size"}, {30'd0, data_size}, {30'd0, sb[0].size});
            chk({tag, "_wr"}, {31'd0, data_wr}, {31'd0, sb[0].wr});
            chk({tag, "_wdata"}, data_wdata, sb[0].wdata);
            chk({tag, "_stall"}, {31'd0, data_stall}, 32'd1);
        end
    endtask

    task automatic chk_done(input string tag);
        exp_t e;
        chk({tag, "_done_req"}, {31'd0, data_req}, 32'd0);
        chk({tag, "_done_stall"}, {31'd0, data_stall}, 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            exp_rdata = e.rdata;
            chk({tag, "_rdata"}, data_sram_rdata, e.rdata);
        end
    endtask

    // Called at a negedge with the DUT idle. a_dly: req cycles before addr_ok;
    // d_dly: cycles after the addr_ok cycle until data_ok; ls: DONE hold cycles.
    task automatic do_txn(input string tag, input logic [31:0] a, input logic [3:0] w,
                          input logic [31:0] wd, input int a_dly, input int d_dly,
                          input logic [31:0] rd, input int ls);
        data_sram_en    = 1'b1;
        data_sram_wen   = w;
        data_sram_addr  = a;
        data_sram_wdata = wd;
        data_rdata      = rd;
        sb.push_back(make_exp(a, w, wd, rd));
        #1;
        chk({tag, "_idle_stall"}, {31'd0, data_stall}, 32'd1);
        chk({tag, "_idle_req"}, {31'd0, data_req}, 32'd0);
        tick();
        data_sram_en   = 1'b0;
        data_sram_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < a_dly; i++) begin
            chk_req_fields(tag);
            data_addr_ok = 1'b0;
            data_data_ok = (i == 0);
            tick();
        end
        chk_req_fields(tag);
        data_addr_ok = 1'b1;
        data_data_ok = (d_dly == 0);
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        for (int j = 1; j <= d_dly; j++) begin
            chk({tag, "_wait_req"}, {31'd0, data_req}, 32'd0);
            chk({tag, "_wait_stall"}, {31'd0, data_stall}, 32'd1);
            data_data_ok = (j == d_dly);
            tick();
            data_data_ok = 1'b0;
        end
        data_rdata        = 32'hA5A5_5A5A;
        cpu_longest_stall = (ls > 0);
        chk_done(tag);
        for (int k = 0; k < ls; k++) begin
            tick();
            chk({tag, "_hold_req"}, {31'd0, data_req}, 32'd0);
            chk({tag, "_hold_stall"}, {31'd0, data_stall}, 32'd0);
            chk({tag, "_hold_rdata"}, data_sram_rdata, exp_rdata);
        end
        cpu_longest_stall = 1'b0;
        tick();
        chk({tag, "_end_req"}, {31'd0, data_req}, 32'd0);
        chk({tag, "_end_stall"}, {31'd0, data_stall}, 32'd0);
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        exp_rdata         = 32'd0;
        resetn            = 1'b0;
        data_sram_en      = 1'b0;
        data_sram_wen     = 4'd0;
        data_sram_addr    = 32'd0;
        data_sram_wdata   = 32'd0;
        cpu_longest_stall = 1'b0;
        data_rdata        = 32'd0;
        data_addr_ok      = 1'b0;
        data_data_ok      = 1'b0;
        #1;
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_stall", {31'd0, data_stall}, 32'd0);
        chk("rst_rdata", data_sram_rdata, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_size", {30'd0, data_size}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;

        do_txn("rd_zero_wait", 32'h1000_0006, 4'b0000, 32'd0, 0, 0, 32'hDEAD_BEEF, 0);
        do_txn("wr_byte", 32'h0000_0020, 4'b0100, 32'h00AA_0000, 3, 2, 32'h5555_AAAA, 0);
        do_txn("wr_half", 32'h0000_0020, 4'b1100, 32'hBBCC_0000, 3, 2, 32'h6666_7777, 0);
        do_txn("wr_odd_wen", 32'h0000_0031, 4'b0101, 32'h0011_0022, 0, 0, 32'h0, 0);
        do_txn("rd_long_stall", 32'h0000_0080, 4'b0000, 32'd0, 1, 1, 32'h1234_5678, 5);

        // Back-to-back loads with en held high throughout.
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'b0000;
        data_sram_addr = 32'h0000_0040;
        sb.push_back(make_exp(32'h40, 4'b0000, 32'd0, 32'h1111_2222));
        #1;
        chk("b2b_first_stall", {31'd0, data_stall}, 32'd1);
        tick();
        chk_req_fields("b2b_first");
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h1111_2222;
        tick();
        data_addr_ok   = 1'b0;
        data_data_ok   = 1'b0;
        data_sram_addr = 32'h0000_0044;
        chk_done("b2b_first");
        tick();
        sb.push_back(make_exp(32'h44, 4'b0000, 32'd0, 32'h3333_4444));
        chk("b2b_idle_req", {31'd0, data_req}, 32'd0);
        chk("b2b_idle_stall", {31'd0, data_stall}, 32'd1);
        data_data_ok = 1'b1;
        data_rdata   = 32'h9999_9999;
        tick();
        data_data_ok = 1'b0;
        chk_req_fields("b2b_second");
        chk("b2b_idle_dok_ignored", data_sram_rdata, 32'h1111_2222);
        data_sram_en = 1'b0;
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h3333_4444;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        chk_done("b2b_second");
        tick();

        // Reset while waiting for data.
        data_sram_en   = 1'b1;
        data_sram_addr = 32'h0000_0100;
        tick();
        data_sram_en = 1'b0;
        chk("rstmid_req_on", {31'd0, data_req}, 32'd1);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk("rstmid_wait_stall", {31'd0, data_stall}, 32'd1);
        resetn = 1'b0;
        #1;
        exp_rdata = 32'd0;
        chk("rstmid_req", {31'd0, data_req}, 32'd0);
        chk("rstmid_stall", {31'd0, data_stall}, 32'd0);
        chk("rstmid_rdata", data_sram_rdata, 32'd0);
        chk("rstmid_addr", data_addr, 32'd0);
        chk("rstmid_wr_size", {29'd0, data_wr, data_size}, 32'd0);
        chk("rstmid_wdata", data_wdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        do_txn("post_rst_rd", 32'h0000_0044, 4'b0000, 32'd0, 0, 1, 32'hCAFE_F00D, 0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
